// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: controller state encoding.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit subtractor cells: half_sub computes a-b without borrow-in,
// full_sub chains two of them to fold in the incoming borrow.
module half_sub (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic bout1;
    logic bout2;

    half_sub u_hs_ab (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (bout1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_sub u_hs_bin (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (bout2)
    );

    assign bout = bout1 | bout2;
endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, result and
// final borrow registered on the edge that processes the last bit.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    import serial_sub_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bin_q, bin_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               bit_d;
    logic               bit_bout;
    logic               last_bit;

    full_sub u_full_sub (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit = (cnt_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: result bits enter at the MSB so bit 0 ends up at the LSB.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    res_d  = '0;
                    bin_d  = 1'b0;
                    cnt_d  = '0;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {bit_d, res_q[WIDTH-1:1]};
                bin_d  = bit_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d   = {bit_d, res_q[WIDTH-1:1]};
                    borrow_d = bit_bout;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (state_q == SHIFT);
        done       = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_q;
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8): latency, arithmetic corners,
// ignored mid-operation starts, mid-operation reset and back-to-back requests.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int checks;
    int errors;
    logic [7:0] prev_diff;
    logic       prev_bo;

    serial_sub #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'd10; b = 8'd3;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (diff !== 8'd0) begin errors++; $display("FAIL reset_diff got %0d want 0", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
        rst = 1'b0; start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
        prev_diff = 8'd0; prev_bo = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_d, input logic exp_bo);
        int n;
        start = 1'b1; a = av; b = bv;
        tick();
        start = 1'b0; a = 8'hA5; b = 8'h5A;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL op_busy %0d-%0d got %b want 1", av, bv, busy); end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            if (n > 0 && diff !== prev_diff) begin
                errors++; $display("FAIL op_hold_diff %0d-%0d got %0d want %0d", av, bv, diff, prev_diff);
            end
            tick();
            n++;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL op_latency %0d-%0d got %0d want 8", av, bv, n); end
        checks++; if (diff !== exp_d) begin errors++; $display("FAIL op_diff %0d-%0d got %0d want %0d", av, bv, diff, exp_d); end
        checks++; if (borrow_out !== exp_bo) begin errors++; $display("FAIL op_borrow %0d-%0d got %b want %b", av, bv, borrow_out, exp_bo); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL op_done_width %0d-%0d got %b want 0", av, bv, done); end
        checks++; if (diff !== exp_d) begin errors++; $display("FAIL op_diff_hold %0d-%0d got %0d want %0d", av, bv, diff, exp_d); end
        prev_diff = exp_d; prev_bo = exp_bo;
    endtask

    task automatic test_arith();
        run_op(8'd100, 8'd37,  8'd63,  1'b0);
        run_op(8'd5,   8'd9,   8'd252, 1'b1);
        run_op(8'd0,   8'd0,   8'd0,   1'b0);
        run_op(8'd255, 8'd255, 8'd0,   1'b0);
        run_op(8'd0,   8'd1,   8'd255, 1'b1);
        run_op(8'd200, 8'd55,  8'd145, 1'b0);
    endtask

    task automatic test_mid_start();
        int dones;
        int first;
        start = 1'b1; a = 8'd50; b = 8'd20;
        tick();
        start = 1'b0;
        dones = 0; first = -1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 4) begin start = 1'b1; a = 8'd1; b = 8'd2; end
            else start = 1'b0;
            tick();
            if (done === 1'b1) begin
                dones++;
                if (first < 0) begin
                    first = i;
                    checks++; if (diff !== 8'd30) begin errors++; $display("FAIL mid_start_diff got %0d want 30", diff); end
                    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL mid_start_borrow got %b want 0", borrow_out); end
                end
            end
        end
        start = 1'b0;
        checks++; if (dones !== 1) begin errors++; $display("FAIL mid_start_pulses got %0d want 1", dones); end
        checks++; if (first !== 8) begin errors++; $display("FAIL mid_start_latency got %0d want 8", first); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_start_queued got busy=%b want 0", busy); end
        prev_diff = 8'd30; prev_bo = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dones;
        start = 1'b1; a = 8'd9; b = 8'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
        checks++; if (diff !== 8'd0) begin errors++; $display("FAIL rst_mid_diff got %0d want 0", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL rst_mid_borrow got %b want 0", borrow_out); end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d pulses want 0", dones); end
        prev_diff = 8'd0; prev_bo = 1'b0;
        run_op(8'd77, 8'd80, 8'd253, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] td [3];
        logic       tbo [3];
        int dones;
        ta[0] = 8'd200; tb[0] = 8'd57;  td[0] = 8'd143; tbo[0] = 1'b0;
        ta[1] = 8'd10;  tb[1] = 8'd20;  td[1] = 8'd246; tbo[1] = 1'b1;
        ta[2] = 8'd128; tb[2] = 8'd128; td[2] = 8'd0;   tbo[2] = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            start = 1'b1;
            if (i % 10 == 0) begin a = ta[i/10]; b = tb[i/10]; end
            else begin a = 8'($urandom); b = 8'($urandom); end
            tick();
            if (done === 1'b1) begin
                dones++;
                checks++; if (i % 10 != 8) begin errors++; $display("FAIL b2b_timing done at cycle %0d want cycle%%10==8", i); end
                checks++; if (diff !== td[i/10]) begin errors++; $display("FAIL b2b_diff op%0d got %0d want %0d", i/10, diff, td[i/10]); end
                checks++; if (borrow_out !== tbo[i/10]) begin errors++; $display("FAIL b2b_borrow op%0d got %b want %b", i/10, borrow_out, tbo[i/10]); end
            end
        end
        start = 1'b0;
        tick();
        checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", dones); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        prev_diff = 8'd0; prev_bo = 1'b0;
        test_reset();
        test_arith();
        test_mid_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
